// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad controller: drives one row low at a time, samples the
// columns, debounces every key serially and queues press/release events in a FIFO.
module keypad_scanner #(
    parameter int ROWS           = 5,
    parameter int COLS           = 5,
    parameter int CLOCKS_PER_ROW = 200000,
    parameter int SAMPLE_OFFSET  = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLS-1:0]      col,
    output wire  [ROWS-1:0]      row,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 scan_done,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [7:0]           evt_code,
    output logic                 evt_press,
    output logic                 overflow,
    input  logic                 ovf_clr
);
    localparam int NKEYS = ROWS * COLS;
    localparam int CNT_W = $clog2(CLOCKS_PER_ROW);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int KEY_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLOCKS_PER_ROW - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_OFFSET);
    localparam logic [CNT_W-1:0] CNT_EVAL0  = CNT_W'(SAMPLE_OFFSET + 1);
    localparam logic [CNT_W-1:0] CNT_NCOLS  = CNT_W'(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_SCANS);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [COLS-1:0]  samp_q, samp_d;
    logic [NKEYS-1:0] key_state_q, key_state_d;
    logic [3:0]       deb_q [NKEYS];
    logic [3:0]       deb_d [NKEYS];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [8:0]       fifo_mem_q [FIFO_DEPTH];

    logic [CNT_W-1:0] eval_off;
    logic [COL_W-1:0] eval_col;
    logic [KEY_W-1:0] eval_key;
    logic             eval_en;
    logic             eval_sample;
    logic             deb_hit;
    logic [3:0]       deb_inc;

    logic [PTR_W:0]   fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [8:0]       push_entry_d;
    logic [8:0]       head;

    genvar gi;

    // Open-drain style row drive: only the active row is pulled low.
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        assign row[gi] = (row_idx_q == ROW_W'(gi)) ? 1'b0 : 1'bz;
    end

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        row_idx_d = row_idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + ROW_W'(1);
        end
        samp_d = (cnt_q == CNT_SAMPLE) ? ~col : samp_q;
    end

    // One key of the active row is evaluated per clock right after the sample.
    always_comb begin
        eval_off    = cnt_q - CNT_EVAL0;
        eval_en     = (cnt_q >= CNT_EVAL0) && (eval_off < CNT_NCOLS);
        eval_col    = COL_W'(eval_off);
        eval_key    = KEY_W'(int'(row_idx_q) * COLS + int'(eval_col));
        eval_sample = samp_q[eval_col];
        deb_inc     = deb_q[eval_key] + 4'd1;
        deb_hit     = eval_en && (eval_sample != key_state_q[eval_key]) && (deb_inc == DEB_TARGET);
    end

    always_comb begin
        deb_d       = deb_q;
        key_state_d = key_state_q;
        if (eval_en) begin
            if (eval_sample == key_state_q[eval_key]) begin
                deb_d[eval_key] = '0;
            end else if (deb_hit) begin
                deb_d[eval_key]       = '0;
                key_state_d[eval_key] = eval_sample;
            end else begin
                deb_d[eval_key] = deb_inc;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    always_comb begin
        fifo_cnt     = wr_ptr_q - rd_ptr_q;
        fifo_empty   = (fifo_cnt == '0);
        fifo_full    = (fifo_cnt == FIFO_FULL);
        pop          = !fifo_empty && evt_ready;
        push_ok      = deb_hit && (!fifo_full || pop);
        drop         = deb_hit && !push_ok;
        push_entry_d = {eval_sample, 8'(eval_key)};
        wr_ptr_d     = push_ok ? wr_ptr_q + (PTR_W + 1)'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + (PTR_W + 1)'(1) : rd_ptr_q;
        if (drop)
            overflow_d = 1'b1;
        else if (ovf_clr)
            overflow_d = 1'b0;
        else
            overflow_d = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            row_idx_q   <= '0;
            samp_q      <= '0;
            key_state_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < NKEYS; i++) deb_q[i] <= '0;
        end else begin
            cnt_q       <= cnt_d;
            row_idx_q   <= row_idx_d;
            samp_q      <= samp_d;
            key_state_q <= key_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            deb_q       <= deb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry_d;
    end

    always_comb begin
        head      = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
        evt_valid = !fifo_empty;
        evt_code  = evt_valid ? head[7:0] : 8'd0;
        evt_press = evt_valid && head[8];
        key_state = key_state_q;
        overflow  = overflow_q;
        scan_done = (cnt_q == CNT_LAST) && (row_idx_q == ROW_LAST);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives col from the live row lines,
// a reference model predicts every event and a handshake monitor scores the FIFO output.
module tb_keypad_scanner;
    localparam int R     = 5;
    localparam int C     = 5;
    localparam int CPR   = 16;
    localparam int SO    = 8;
    localparam int DEB   = 2;
    localparam int FD    = 4;
    localparam int FRAME = R * CPR;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           evt_ready = 1'b0;
    logic           ovf_clr = 1'b0;
    logic [C-1:0]   col;
    wire  [R-1:0]   row_w;
    logic [R*C-1:0] key_state;
    logic           scan_done;
    logic           evt_valid;
    logic [7:0]     evt_code;
    logic           evt_press;
    logic           overflow;

    logic [C-1:0]   pressed [R];

    int checks = 0;
    int passes = 0;

    // Reference model state
    int         t = 0;
    bit         started = 1'b0;
    bit         empty_since_rst = 1'b1;
    bit         mkey [R*C];
    int         mdeb [R*C];
    logic [C-1:0] msamp;
    bit         movf;
    logic [8:0] mfifo [$];
    logic [8:0] exp_q [$];
    int         m_cnt, m_r, m_c, m_k;
    bit         m_have, m_pop, m_drop;
    logic [8:0] m_ev;

    // Monitor state
    int         pop_cnt = 0;
    int         mon_r;
    logic [R-1:0] mon_row;
    logic [8:0] mon_exp;
    logic [7:0] last_code;
    logic       last_press;

    genvar gi;
    for (gi = 0; gi < R; gi++) begin : g_pu
        pullup (row_w[gi]);
    end

    keypad_scanner #(
        .ROWS(R), .COLS(C), .CLOCKS_PER_ROW(CPR), .SAMPLE_OFFSET(SO),
        .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .col(col), .row(row_w), .key_state(key_state),
        .scan_done(scan_done), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_press(evt_press), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // A pressed key connects its column to its row line.
    always_comb begin
        col = '1;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (pressed[r][c] && row_w[r] == 1'b0) col[c] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [R*C-1:0] mkey_vec();
        logic [R*C-1:0] v;
        for (int k = 0; k < R*C; k++) v[k] = mkey[k];
        return v;
    endfunction

    // Reference model: position in the frame comes from elapsed clocks since reset.
    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            msamp = '0;
            movf = 1'b0;
            mfifo.delete();
            exp_q.delete();
            started = 1'b1;
            empty_since_rst = 1'b1;
            for (int k = 0; k < R*C; k++) begin
                mkey[k] = 1'b0;
                mdeb[k] = 0;
            end
        end else if (started) begin
            m_cnt  = t % CPR;
            m_r    = (t / CPR) % R;
            m_have = 1'b0;
            m_drop = 1'b0;
            m_ev   = '0;
            m_pop  = (mfifo.size() != 0) && evt_ready;
            if (m_cnt == SO) msamp = pressed[m_r];
            if (m_cnt > SO && m_cnt <= SO + C) begin
                m_c = m_cnt - SO - 1;
                m_k = m_r * C + m_c;
                if (msamp[m_c] == mkey[m_k]) begin
                    mdeb[m_k] = 0;
                end else begin
                    mdeb[m_k]++;
                    if (mdeb[m_k] == DEB) begin
                        mkey[m_k] = !mkey[m_k];
                        mdeb[m_k] = 0;
                        m_have = 1'b1;
                        m_ev = {mkey[m_k], 8'(m_k)};
                    end
                end
            end
            if (m_pop) void'(mfifo.pop_front());
            if (m_have) begin
                if (mfifo.size() < FD) begin
                    mfifo.push_back(m_ev);
                    exp_q.push_back(m_ev);
                    empty_since_rst = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
            if (m_drop) movf = 1'b1;
            else if (ovf_clr) movf = 1'b0;
            t++;
        end
    end

    // Monitor: per-cycle state checks and scoreboard pops on each handshake.
    always @(negedge clk) begin
        if (started) begin
            mon_r = (t / CPR) % R;
            mon_row = '1;
            mon_row[mon_r] = 1'b0;
            chk("row", row_w, mon_row);
            chk("scan_done", scan_done, (t % CPR == CPR - 1) && (mon_r == R - 1));
            chk("key_state", key_state, mkey_vec());
            chk("overflow", overflow, movf);
            chk("evt_valid", evt_valid, mfifo.size() != 0);
            if (empty_since_rst && !evt_valid) begin
                chk("empty_code", evt_code, 0);
                chk("empty_press", evt_press, 0);
            end
            if (!rst && evt_valid && evt_ready) begin
                chk("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("evt_code", evt_code, mon_exp[7:0]);
                    chk("evt_press", evt_press, mon_exp[8]);
                end
                pop_cnt++;
                last_code = evt_code;
                last_press = evt_press;
                $display("evt code=%0d press=%0d t=%0t", evt_code, evt_press, $time);
            end
        end
    end

    task automatic step(input int n, input bit rnd);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                ovf_clr = ($urandom_range(0, 49) == 0);
            end
        end
    endtask

    task automatic clear_keys();
        for (int r = 0; r < R; r++) pressed[r] = '0;
    endtask

    int pc;
    int sdc;

    initial begin
        clear_keys();
        rst = 1'b1;
        step(3, 0);
        rst = 1'b0;

        // Idle frame: one scan_done, no events
        pc = pop_cnt;
        sdc = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1, 0);
            if (scan_done) sdc++;
        end
        chk("idle_scan_done_count", sdc, 1);
        chk("idle_events", pop_cnt - pc, 0);
        chk("idle_evt_valid", evt_valid, 0);

        // Hold r2c3 for 3 frames
        evt_ready = 1'b1;
        pc = pop_cnt;
        pressed[2][3] = 1'b1;
        step(3 * FRAME, 0);
        chk("hold_key13", key_state[13], 1);
        chk("hold_events", pop_cnt - pc, 1);
        chk("hold_code", last_code, 13);
        chk("hold_press", last_press, 1);
        clear_keys();
        step(2 * FRAME, 0);
        chk("release_key13", key_state[13], 0);
        chk("release_press", last_press, 0);

        // Single-frame glitches never reach the debounce threshold
        pc = pop_cnt;
        repeat (2) begin
            pressed[2][3] = 1'b1;
            step(FRAME, 0);
            clear_keys();
            step(FRAME, 0);
        end
        chk("glitch_key13", key_state[13], 0);
        chk("glitch_events", pop_cnt - pc, 0);

        // Row 0 all pressed with no consumer: FIFO fills, rest dropped
        evt_ready = 1'b0;
        pressed[0] = 5'b11111;
        step(2 * FRAME, 0);
        clear_keys();
        step(2 * FRAME, 0);
        chk("ovf_keys_row0", key_state[4:0], 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_evt_valid", evt_valid, 1);

        // Drain and clear the flag
        pc = pop_cnt;
        evt_ready = 1'b1;
        ovf_clr = 1'b1;
        step(1, 0);
        ovf_clr = 1'b0;
        step(10, 0);
        chk("drain_events", pop_cnt - pc, 4);
        chk("drain_last_code", last_code, 3);
        chk("drain_overflow", overflow, 0);
        chk("drain_evt_valid", evt_valid, 0);

        // Randomized key patterns and consumer backpressure
        repeat (14) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    pressed[r][c] = ($urandom_range(0, 3) == 0);
            step($urandom_range(40, 250), 1);
        end
        clear_keys();
        evt_ready = 1'b1;
        ovf_clr = 1'b0;
        step(3 * FRAME, 0);
        chk("random_sb_empty", exp_q.size(), 0);

        // Reset during row 3 with two events queued
        rst = 1'b1;
        step(1, 0);
        rst = 1'b0;
        evt_ready = 1'b0;
        pressed[1] = 5'b00011;
        step(2 * FRAME + 3 * CPR + 4, 0);
        chk("prereset_evt_valid", evt_valid, 1);
        chk("prereset_queued", mfifo.size(), 2);
        clear_keys();
        rst = 1'b1;
        step(1, 0);
        rst = 1'b0;
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_key_state", key_state, 0);
        chk("rst_row", row_w, 5'b11110);
        chk("rst_evt_code", evt_code, 0);
        step(FRAME - 1, 0);
        chk("rst_frame_scan_done", scan_done, 1);
        step(1, 0);
        chk("rst_frame_wrap", scan_done, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
